// File: rtl/cal_addtree_acc.sv
// ============================================================================
// Module      : cal_addtree_acc
// Description : Pipelined signed adder tree with multi-pass accumulation and
//               requantisation for conv/FC layers. Each valid beat sums N_IN
//               products (plus the bias on the first channel pass). Beats are
//               accumulated across input-channel passes. On the last pass the
//               accumulator is rounded half up, arithmetically shifted right
//               and saturated to an OUT_W activation.
//
//               Pipeline:
//                 stage 1 : sign-extend terms, register 3-term group sums
//                 stage 2 : register beat sum of all groups
//                 stage 3 : saturating accumulate, sticky overflow
//                 stage 4 : round, shift, (ReLU), saturate, register output
//
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   beat valid
//               in_first   first channel pass (adds bias, restarts acc)
//               in_last    last channel pass (produces an output)
//               din        packed signed products, element k at [k*IN_W +: IN_W]
//               bias       signed bias, used only on valid first beats
//               shift      requantisation right shift 0..15 (quasi-static)
//               out_valid  one-cycle pulse, dout/acc_ovf valid
//               dout       signed saturated activation
//               acc_ovf    accumulator saturated during this output
//
// Options     : define ADDTREE_RELU_EN to clamp negative results to 0 before
//               output saturation.
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cal_addtree_acc #(
  parameter int N_IN  = 8,
  parameter int IN_W  = 12,
  parameter int ACC_W = 20,
  parameter int OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [N_IN*IN_W-1:0]   din,
  input  logic [IN_W-1:0]        bias,
  input  logic [3:0]             shift,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       dout,
  output logic                   acc_ovf
);

  // N_IN products plus one bias slot, padded to whole groups of three.
  localparam int c_NGRP  = (N_IN + 3) / 3;
  localparam int c_NTERM = 3 * c_NGRP;

  localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Stage 1: term extension and 3-input group sums
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] w_term [c_NTERM];
  logic signed [ACC_W-1:0] w_grp  [c_NGRP];

  generate
    for (genvar k = 0; k < c_NTERM; k++) begin : g_term
      if (k < N_IN) begin : g_prod
        assign w_term[k] = {{(ACC_W-IN_W){din[k*IN_W+IN_W-1]}}, din[k*IN_W +: IN_W]};
      end else if (k == N_IN) begin : g_bias
        assign w_term[k] = in_first ? {{(ACC_W-IN_W){bias[IN_W-1]}}, bias} : '0;
      end else begin : g_pad
        assign w_term[k] = '0;
      end
    end

    for (genvar g = 0; g < c_NGRP; g++) begin : g_grp
      assign w_grp[g] = w_term[3*g] + w_term[3*g+1] + w_term[3*g+2];
    end
  endgenerate

  logic signed [ACC_W-1:0] r_s1_grp [c_NGRP];
  logic                    r_s1_valid;
  logic                    r_s1_first;
  logic                    r_s1_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < c_NGRP; g++) r_s1_grp[g] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      for (int g = 0; g < c_NGRP; g++) r_s1_grp[g] <= w_grp[g];
      r_s1_valid <= in_valid;
      r_s1_first <= in_valid & in_first;
      r_s1_last  <= in_valid & in_last;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: beat sum. ACC_W >= IN_W+5 covers up to 17 terms without wrap.
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] w_beat_sum;

  always_comb begin
    w_beat_sum = '0;
    for (int g = 0; g < c_NGRP; g++) w_beat_sum = w_beat_sum + r_s1_grp[g];
  end

  logic signed [ACC_W-1:0] r_s2_sum;
  logic                    r_s2_valid;
  logic                    r_s2_first;
  logic                    r_s2_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_sum   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_sum   <= w_beat_sum;
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: saturating accumulator with sticky overflow
  // --------------------------------------------------------------------------
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_ovf;
  logic                    r_s3_valid;
  logic                    r_s3_last;

  logic signed [ACC_W:0]   w_acc_sum;
  logic                    w_acc_ovf;
  logic signed [ACC_W-1:0] w_acc_sat;

  // One guard bit: overflow whenever the two top bits disagree.
  always_comb begin
    w_acc_sum = {r_acc[ACC_W-1], r_acc} + {r_s2_sum[ACC_W-1], r_s2_sum};
    w_acc_ovf = w_acc_sum[ACC_W] ^ w_acc_sum[ACC_W-1];
    if (w_acc_ovf) begin
      w_acc_sat = w_acc_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
    end else begin
      w_acc_sat = w_acc_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
    end else begin
      if (r_s2_valid && r_s2_first) begin
        r_acc <= r_s2_sum;
        r_ovf <= 1'b0;
      end else if (r_s2_valid) begin
        r_acc <= w_acc_sat;
        r_ovf <= r_ovf | w_acc_ovf;
      end
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_valid & r_s2_last;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 4: round half up, arithmetic shift, optional ReLU, saturate
  // --------------------------------------------------------------------------
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_rsum;
  logic signed [ACC_W:0]   w_rsh;
  logic signed [ACC_W:0]   w_act;
  logic [ACC_W:OUT_W-1]    w_hi;
  logic [OUT_W-1:0]        w_out;

  always_comb begin
    w_rnd = '0;
    if (shift != 4'd0) w_rnd = (ACC_W+1)'(1) << (shift - 4'd1);
    // Extra bit keeps acc_max + rounding constant from wrapping.
    w_rsum = {r_acc[ACC_W-1], r_acc} + w_rnd;
    w_rsh  = w_rsum >>> shift;
`ifdef ADDTREE_RELU_EN
    w_act = w_rsh[ACC_W] ? '0 : w_rsh;
`else
    w_act = w_rsh;
`endif
    // Fits in OUT_W iff every bit above the output sign bit matches it.
    w_hi = w_act[ACC_W:OUT_W-1];
    if ((&w_hi) || !(|w_hi)) begin
      w_out = w_act[OUT_W-1:0];
    end else if (w_act[ACC_W]) begin
      w_out = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      w_out = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      out_valid <= r_s3_valid & r_s3_last;
      if (r_s3_valid && r_s3_last) begin
        dout    <= w_out;
        acc_ovf <= r_ovf;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cal_addtree_acc.sv
// ============================================================================
// Module      : tb_cal_addtree_acc
// Description : Directed self-checking bench for cal_addtree_acc with the
//               default parameters (N_IN=8, IN_W=12, ACC_W=20, OUT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cal_addtree_acc;

  localparam int N_IN  = 8;
  localparam int IN_W  = 12;
  localparam int ACC_W = 20;
  localparam int OUT_W = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_first;
  logic                 in_last;
  logic [N_IN*IN_W-1:0] din;
  logic [IN_W-1:0]      bias;
  logic [3:0]           shift;
  logic                 out_valid;
  logic [OUT_W-1:0]     dout;
  logic                 acc_ovf;

  int checks;
  int errors;
  int cyc;

  logic [OUT_W-1:0] q_dout [$];
  logic             q_ovf  [$];
  int               q_cyc  [$];

  cal_addtree_acc #(
    .N_IN  (N_IN),
    .IN_W  (IN_W),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .din       (din),
    .bias      (bias),
    .shift     (shift),
    .out_valid (out_valid),
    .dout      (dout),
    .acc_ovf   (acc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      q_dout.push_back(dout);
      q_ovf.push_back(acc_ovf);
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] d8(int v);
    logic [OUT_W-1:0] t;
    t = OUT_W'(v);
    return {24'h0, t};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_din(int v);
    for (int k = 0; k < N_IN; k++) din[k*IN_W +: IN_W] = IN_W'(v);
  endtask

  task automatic send(bit f, bit l, int dv, int bv);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    set_din(dv);
    bias = IN_W'(bv);
    step();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_n(string tag, int n);
    chk(tag, 32'(q_dout.size()), 32'(n));
  endtask

  task automatic pop_chk(string tag, int exp_d, bit exp_o);
    logic [OUT_W-1:0] d;
    logic             o;
    if (q_dout.size() > 0) begin
      d = q_dout.pop_front();
      o = q_ovf.pop_front();
      void'(q_cyc.pop_front());
      chk({tag, "_dout"}, {24'h0, d}, d8(exp_d));
      chk({tag, "_ovf"}, {31'h0, o}, {31'h0, exp_o});
    end
  endtask

  initial begin
    int c0;
    int c1;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    din      = '0;
    bias     = '0;
    shift    = 4'd0;

    // Reset state
    idle(3);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_dout", {24'h0, dout}, 32'd0);
    chk("rst_acc_ovf", {31'h0, acc_ovf}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Last without first after reset accumulates onto 0: 8*1 = 8
    send(1'b0, 1'b1, 1, 5);
    idle(6);
    expect_n("lastonly_cnt", 1);
    pop_chk("lastonly", 8, 1'b0);

    // Exact latency: 8*1 + 3 = 11, out_valid four edges after presentation
    q_dout.delete(); q_ovf.delete(); q_cyc.delete();
    send(1'b1, 1'b1, 1, 3);
    idle(2);
    chk("lat_early", {31'h0, out_valid}, 32'd0);
    step();
    chk("lat_valid", {31'h0, out_valid}, 32'd1);
    chk("lat_dout", {24'h0, dout}, d8(11));
    chk("lat_ovf", {31'h0, acc_ovf}, 32'd0);
    step();
    chk("lat_pulse", {31'h0, out_valid}, 32'd0);
    idle(2);
    q_dout.delete(); q_ovf.delete(); q_cyc.delete();

    // Three passes with a bubble: 20 + 8 - 8 = 20; (20+2)>>2 = 5
    shift = 4'd2;
    send(1'b1, 1'b0, 2, 4);
    send(1'b0, 1'b0, 1, 0);
    idle(1);
    send(1'b0, 1'b1, -1, 0);
    idle(6);
    expect_n("multi_cnt", 1);
    pop_chk("multi", 5, 1'b0);

    // 18423 -> (18423+8)>>4 = 1151 -> saturates to 127
    shift = 4'd4;
    send(1'b1, 1'b1, 2047, 2047);
    idle(6);
    expect_n("possat_cnt", 1);
    pop_chk("possat", 127, 1'b0);

    // -40 -> (-40+8)>>>4 = -2, or 0 with ReLU
    send(1'b1, 1'b1, -5, 0);
    idle(6);
    expect_n("neg_cnt", 1);
`ifdef ADDTREE_RELU_EN
    pop_chk("neg", 0, 1'b0);
`else
    pop_chk("neg", -2, 1'b0);
`endif

    // 40 x 16376 overflows; acc clamps at 524287 -> (524287+16384)>>15 = 16
    shift = 4'd15;
    for (int b = 1; b <= 40; b++) send(b == 1, b == 40, 2047, 0);
    idle(6);
    expect_n("accsat_cnt", 1);
    pop_chk("accsat", 16, 1'b1);
    send(1'b1, 1'b1, 0, 0);
    idle(6);
    expect_n("ovfclr_cnt", 1);
    pop_chk("ovfclr", 0, 1'b0);

    // Back-to-back single-pass outputs on consecutive cycles: 8 then 16
    shift = 4'd0;
    send(1'b1, 1'b1, 1, 0);
    send(1'b1, 1'b1, 2, 0);
    idle(6);
    expect_n("b2b_cnt", 2);
    if (q_cyc.size() == 2) begin
      c0 = q_cyc[0];
      c1 = q_cyc[1];
      chk("b2b_gap", 32'(c1 - c0), 32'd1);
    end
    pop_chk("b2b0", 8, 1'b0);
    pop_chk("b2b1", 16, 1'b0);

    // Abandoned accumulation: restart gives 8*1 + 1 = 9, single output
    send(1'b1, 1'b0, 3, 0);
    send(1'b1, 1'b1, 1, 1);
    idle(6);
    expect_n("abandon_cnt", 1);
    pop_chk("abandon", 9, 1'b0);

    // Reset mid-accumulation discards in-flight work
    send(1'b1, 1'b0, 1, 0);
    send(1'b0, 1'b1, 1, 0);
    rst_n = 1'b0;
    step();
    chk("midrst_valid", {31'h0, out_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    idle(6);
    expect_n("midrst_stray", 0);
    send(1'b1, 1'b1, 1, 0);
    idle(6);
    expect_n("midrst_cnt", 1);
    pop_chk("midrst", 8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
